// File: rtl/hit_edge_pkg.sv
// Shared edge codes, sprite defaults and reporter state encoding
// for the enemy/player hit logic.
package hit_edge_pkg;

    localparam logic [3:0] EDGE_NONE   = 4'b0000;
    localparam logic [3:0] EDGE_BOTTOM = 4'b0001;
    localparam logic [3:0] EDGE_RIGHT  = 4'b0010;
    localparam logic [3:0] EDGE_TOP    = 4'b0100;
    localparam logic [3:0] EDGE_LEFT   = 4'b1000;

    localparam int OBJECT_WIDTH_X_DEF = 32;
    localparam int OBJECT_HIGHT_Y_DEF = 32;
    localparam int EDGE_BAND_DEF      = 8;

    typedef enum logic [1:0] {
        IDLE_ST,
        ARMED_ST,
        REPORTED_ST
    } hit_state_t;

endpackage

// File: rtl/hit_edge_classifier.sv
// Combinational pixel-offset to one-hot edge code classifier.
// Top/bottom bands own the corners; out-of-sprite offsets give none.
module hit_edge_classifier
    import hit_edge_pkg::*;
#(
    parameter int OBJECT_WIDTH_X = OBJECT_WIDTH_X_DEF,
    parameter int OBJECT_HIGHT_Y = OBJECT_HIGHT_Y_DEF,
    parameter int EDGE_BAND      = EDGE_BAND_DEF
) (
    input  logic signed [10:0] offsetX,
    input  logic signed [10:0] offsetY,
    output logic        [3:0]  code
);

    localparam logic signed [10:0] W_L    = 11'(OBJECT_WIDTH_X);
    localparam logic signed [10:0] H_L    = 11'(OBJECT_HIGHT_Y);
    localparam logic signed [10:0] BAND_L = 11'(EDGE_BAND);
    localparam logic signed [10:0] BOT_L  = H_L - BAND_L;
    localparam logic signed [10:0] RGT_L  = W_L - BAND_L;

    logic in_sprite;

    // Offset must lie inside the sprite rectangle to be classified.
    always_comb begin
        in_sprite = !offsetX[10] && !offsetY[10] &&
                    (offsetX < W_L) && (offsetY < H_L);
    end

    // Band priority: top, bottom, left, right, else centre.
    always_comb begin
        code = EDGE_NONE;
        if (in_sprite) begin
            if (offsetY < BAND_L)
                code = EDGE_TOP;
            else if (offsetY >= BOT_L)
                code = EDGE_BOTTOM;
            else if (offsetX < BAND_L)
                code = EDGE_LEFT;
            else if (offsetX >= RGT_L)
                code = EDGE_RIGHT;
        end
    end

endmodule

// File: rtl/enemy_hit_reporter.sv
// Per-frame enemy collision reporter: one pulse and held edge code.
// Optional stats ports are enabled by ENEMY_HIT_STATS_EN.
module enemy_hit_reporter
    import hit_edge_pkg::*;
#(
    parameter int OBJECT_WIDTH_X     = OBJECT_WIDTH_X_DEF,
    parameter int OBJECT_HIGHT_Y     = OBJECT_HIGHT_Y_DEF,
    parameter int EDGE_BAND          = EDGE_BAND_DEF,
    parameter int MIN_OVERLAP_PIXELS = 2
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enemyDR,
    input  logic               obstacleDR,
    input  logic signed [10:0] offsetX,
    input  logic signed [10:0] offsetY,
`ifdef ENEMY_HIT_STATS_EN
    output logic        [15:0] hit_frames,
    output logic        [3:0]  last_edge,
`endif
    output logic               collision,
    output logic        [3:0]  HitEdgeCode
);

    localparam logic [7:0] MIN_L = 8'(MIN_OVERLAP_PIXELS);

    hit_state_t state;
    logic [7:0] pix_cnt;
    logic [7:0] cnt_inc;
    logic [3:0] pix_code;
    logic       qual;
    logic       report;

    hit_edge_classifier #(
        .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
        .OBJECT_HIGHT_Y (OBJECT_HIGHT_Y),
        .EDGE_BAND      (EDGE_BAND)
    ) u_classifier (
        .offsetX (offsetX),
        .offsetY (offsetY),
        .code    (pix_code)
    );

    // Qualifying pixel detect, saturating increment and report edge.
    always_comb begin
        qual    = enemyDR && obstacleDR && (pix_code != EDGE_NONE);
        cnt_inc = (pix_cnt == 8'hFF) ? pix_cnt : pix_cnt + 8'd1;
        report  = (state == ARMED_ST) && !startOfFrame &&
                  qual && (cnt_inc == MIN_L);
    end

    // Frame state machine with registered pulse and edge code.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE_ST;
            pix_cnt     <= 8'd0;
            collision   <= 1'b0;
            HitEdgeCode <= EDGE_NONE;
        end else begin
            unique case (state)
                IDLE_ST: begin
                    collision   <= 1'b0;
                    HitEdgeCode <= EDGE_NONE;
                    pix_cnt     <= 8'd0;
                    if (startOfFrame)
                        state <= ARMED_ST;
                end
                ARMED_ST: begin
                    if (startOfFrame) begin
                        pix_cnt     <= 8'd0;
                        collision   <= 1'b0;
                        HitEdgeCode <= EDGE_NONE;
                    end else if (qual) begin
                        pix_cnt <= cnt_inc;
                        if (report) begin
                            collision   <= 1'b1;
                            HitEdgeCode <= pix_code;
                            state       <= REPORTED_ST;
                        end
                    end
                end
                REPORTED_ST: begin
                    collision <= 1'b0;
                    if (startOfFrame) begin
                        pix_cnt     <= 8'd0;
                        HitEdgeCode <= EDGE_NONE;
                        state       <= ARMED_ST;
                    end
                end
                default: begin
                    state <= IDLE_ST;
                end
            endcase
        end
    end

`ifdef ENEMY_HIT_STATS_EN
    // Reported-frame count (saturating) and sticky last edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_frames <= 16'd0;
            last_edge  <= EDGE_NONE;
        end else if (report) begin
            if (hit_frames != 16'hFFFF)
                hit_frames <= hit_frames + 16'd1;
            last_edge <= pix_code;
        end
    end
`endif

endmodule

// File: tb/tb_enemy_hit_reporter.sv
// Scoreboard bench for enemy_hit_reporter: expected {collision,code}
// pushed per driven cycle, popped and compared after the clock edge.
module tb_enemy_hit_reporter;

    logic               clk;
    logic               resetN;
    logic               startOfFrame;
    logic               enemyDR;
    logic               obstacleDR;
    logic signed [10:0] offsetX;
    logic signed [10:0] offsetY;
    logic               collision;
    logic        [3:0]  HitEdgeCode;
`ifdef ENEMY_HIT_STATS_EN
    logic        [15:0] hit_frames;
    logic        [3:0]  last_edge;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_BOT  = 4'b0001;
    localparam logic [3:0] C_RGT  = 4'b0010;
    localparam logic [3:0] C_TOP  = 4'b0100;
    localparam logic [3:0] C_LFT  = 4'b1000;

    typedef struct {
        bit         sof;
        bit         en;
        bit         ob;
        int         x;
        int         y;
        logic [4:0] exp;
    } step_t;

    logic [4:0] exp_q[$];

    enemy_hit_reporter dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .enemyDR      (enemyDR),
        .obstacleDR   (obstacleDR),
        .offsetX      (offsetX),
        .offsetY      (offsetY),
`ifdef ENEMY_HIT_STATS_EN
        .hit_frames   (hit_frames),
        .last_edge    (last_edge),
`endif
        .collision    (collision),
        .HitEdgeCode  (HitEdgeCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic step_t mk(bit sof, bit en, bit ob, int x, int y,
                                 bit col, logic [3:0] code);
        step_t s;
        s.sof = sof;
        s.en  = en;
        s.ob  = ob;
        s.x   = x;
        s.y   = y;
        s.exp = {col, code};
        return s;
    endfunction

    function automatic step_t px(int x, int y, bit col, logic [3:0] code);
        return mk(1'b0, 1'b1, 1'b1, x, y, col, code);
    endfunction

    function automatic step_t idle(bit col, logic [3:0] code);
        return mk(1'b0, 1'b0, 1'b0, 0, 0, col, code);
    endfunction

    function automatic step_t sof_step();
        return mk(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, C_NONE);
    endfunction

    task automatic apply(step_t s);
        exp_q.push_back(s.exp);
        @(negedge clk);
        startOfFrame = s.sof;
        enemyDR      = s.en;
        obstacleDR   = s.ob;
        offsetX      = 11'(s.x);
        offsetY      = 11'(s.y);
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        enemyDR      = 1'b0;
        obstacleDR   = 1'b0;
    endtask

    task automatic test_reset();
        step_t s[$];
        logic [4:0] got, want;
        resetN = 1'b0;
        startOfFrame = 1'b0;
        enemyDR = 1'b0;
        obstacleDR = 1'b0;
        offsetX = '0;
        offsetY = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({collision, HitEdgeCode} !== 5'b0) begin
            failures++;
            $display("FAIL reset_state: got %b expected %b",
                     {collision, HitEdgeCode}, 5'b0);
        end
        @(negedge clk);
        resetN = 1'b1;
        s.push_back(px(16, 3, 1'b0, C_NONE));
        s.push_back(px(17, 3, 1'b0, C_NONE));
        s.push_back(px(18, 3, 1'b0, C_NONE));
        foreach (s[i]) begin
            apply(s[i]);
            got  = {collision, HitEdgeCode};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL idle_no_frame step %0d: got %b expected %b",
                         i, got, want);
            end
        end
    endtask

    task automatic test_top_edge();
        step_t s[$];
        logic [4:0] got, want;
        s.push_back(sof_step());
        s.push_back(px(16, 3, 1'b0, C_NONE));
        s.push_back(px(17, 3, 1'b1, C_TOP));
        s.push_back(idle(1'b0, C_TOP));
        s.push_back(px(18, 3, 1'b0, C_TOP));
        s.push_back(idle(1'b0, C_TOP));
        s.push_back(sof_step());
        foreach (s[i]) begin
            apply(s[i]);
            got  = {collision, HitEdgeCode};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL top_edge step %0d: got %b expected %b",
                         i, got, want);
            end
        end
    endtask

    task automatic test_right_single_pulse();
        step_t s[$];
        logic [4:0] got, want;
        s.push_back(px(30, 16, 1'b0, C_NONE));
        s.push_back(px(31, 16, 1'b1, C_RGT));
        s.push_back(px(2, 16, 1'b0, C_RGT));
        s.push_back(idle(1'b0, C_RGT));
        s.push_back(sof_step());
        foreach (s[i]) begin
            apply(s[i]);
            got  = {collision, HitEdgeCode};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL right_single step %0d: got %b expected %b",
                         i, got, want);
            end
        end
    endtask

    task automatic test_no_carry();
        step_t s[$];
        logic [4:0] got, want;
        s.push_back(px(16, 28, 1'b0, C_NONE));
        s.push_back(idle(1'b0, C_NONE));
        s.push_back(sof_step());
        s.push_back(px(16, 28, 1'b0, C_NONE));
        s.push_back(idle(1'b0, C_NONE));
        s.push_back(sof_step());
        foreach (s[i]) begin
            apply(s[i]);
            got  = {collision, HitEdgeCode};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL no_carry step %0d: got %b expected %b",
                         i, got, want);
            end
        end
    endtask

    task automatic test_centre_then_bottom();
        step_t s[$];
        logic [4:0] got, want;
        for (int k = 0; k < 10; k++)
            s.push_back(px(16, 16, 1'b0, C_NONE));
        s.push_back(px(16, 30, 1'b0, C_NONE));
        s.push_back(px(16, 31, 1'b1, C_BOT));
        s.push_back(idle(1'b0, C_BOT));
        s.push_back(sof_step());
        foreach (s[i]) begin
            apply(s[i]);
            got  = {collision, HitEdgeCode};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL centre_bottom step %0d: got %b expected %b",
                         i, got, want);
            end
        end
    endtask

    task automatic test_boundaries();
        step_t s[$];
        logic [4:0] got, want;
        s.push_back(px(-1, 3, 1'b0, C_NONE));
        s.push_back(px(16, 32, 1'b0, C_NONE));
        s.push_back(px(32, 16, 1'b0, C_NONE));
        s.push_back(px(8, 16, 1'b0, C_NONE));
        s.push_back(px(23, 16, 1'b0, C_NONE));
        s.push_back(px(16, 8, 1'b0, C_NONE));
        s.push_back(px(16, 23, 1'b0, C_NONE));
        s.push_back(mk(1'b0, 1'b1, 1'b0, 16, 3, 1'b0, C_NONE));
        s.push_back(mk(1'b0, 1'b0, 1'b1, 16, 3, 1'b0, C_NONE));
        s.push_back(px(7, 16, 1'b0, C_NONE));
        s.push_back(px(24, 16, 1'b1, C_RGT));
        s.push_back(sof_step());
        s.push_back(px(0, 0, 1'b0, C_NONE));
        s.push_back(px(31, 31, 1'b1, C_BOT));
        s.push_back(sof_step());
        s.push_back(px(7, 24, 1'b0, C_NONE));
        s.push_back(px(0, 7, 1'b1, C_TOP));
        s.push_back(sof_step());
        foreach (s[i]) begin
            apply(s[i]);
            got  = {collision, HitEdgeCode};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL boundaries step %0d: got %b expected %b",
                         i, got, want);
            end
        end
    endtask

    task automatic test_sof_coincident();
        step_t s[$];
        logic [4:0] got, want;
        s.push_back(px(2, 10, 1'b0, C_NONE));
        s.push_back(mk(1'b1, 1'b1, 1'b1, 3, 10, 1'b0, C_NONE));
        s.push_back(px(3, 10, 1'b0, C_NONE));
        s.push_back(px(4, 10, 1'b1, C_LFT));
        s.push_back(sof_step());
        foreach (s[i]) begin
            apply(s[i]);
            got  = {collision, HitEdgeCode};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL sof_coincident step %0d: got %b expected %b",
                         i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t a[$];
        step_t b[$];
        logic [4:0] got, want;
        a.push_back(px(16, 3, 1'b0, C_NONE));
        a.push_back(px(17, 3, 1'b1, C_TOP));
        a.push_back(idle(1'b0, C_TOP));
        a.push_back(sof_step());
        a.push_back(px(16, 3, 1'b0, C_NONE));
        a.push_back(px(17, 3, 1'b1, C_TOP));
        foreach (a[i]) begin
            apply(a[i]);
            got  = {collision, HitEdgeCode};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_mid_pre step %0d: got %b expected %b",
                         i, got, want);
            end
        end
        @(negedge clk);
        resetN = 1'b0;
        #1;
        checks++;
        if ({collision, HitEdgeCode} !== 5'b0) begin
            failures++;
            $display("FAIL async_reset_clear: got %b expected %b",
                     {collision, HitEdgeCode}, 5'b0);
        end
        @(negedge clk);
        resetN = 1'b1;
        apply(sof_step());
        apply(px(16, 3, 1'b0, C_NONE));
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        @(negedge clk);
        resetN = 1'b0;
        #1;
        checks++;
        if ({collision, HitEdgeCode} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid_frame: got %b expected %b",
                     {collision, HitEdgeCode}, 5'b0);
        end
        @(negedge clk);
        resetN = 1'b1;
        b.push_back(px(17, 3, 1'b0, C_NONE));
        b.push_back(px(18, 3, 1'b0, C_NONE));
        b.push_back(sof_step());
        b.push_back(px(16, 3, 1'b0, C_NONE));
        b.push_back(px(17, 3, 1'b1, C_TOP));
        b.push_back(idle(1'b0, C_TOP));
        foreach (b[i]) begin
            apply(b[i]);
            got  = {collision, HitEdgeCode};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_mid_post step %0d: got %b expected %b",
                         i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_top_edge();
        test_right_single_pulse();
        test_no_carry();
        test_centre_then_bottom();
        test_boundaries();
        test_sof_coincident();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left expected 0",
                     exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
